// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, divider tap selection and channel state
// types shared by multi_timer and timer_channel.
package multi_timer_pkg;

    // Register offsets carried in reg_addr[1:0]
    localparam logic [1:0] REG_COUNT   = 2'b00;
    localparam logic [1:0] REG_MODULO  = 2'b01;
    localparam logic [1:0] REG_CONTROL = 2'b10;
    localparam logic [1:0] REG_DIV     = 2'b11;

    // CONTROL[1:0]: which divider bit clocks the channel
    typedef enum logic [1:0] {
        TAP_BIT9 = 2'b00,
        TAP_BIT3 = 2'b01,
        TAP_BIT5 = 2'b10,
        TAP_BIT7 = 2'b11
    } tap_sel_e;

    // Per-channel overflow sequencing (RELOAD only exists with TIMER_OVF_DELAY_EN)
    typedef enum logic {
        IDLE   = 1'b0,
        RELOAD = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one independent COUNT/MODULO/CONTROL timer slice.
// Optional feature macro: TIMER_OVF_DELAY_EN -- when defined, an overflow
// first clears COUNT and spends one cycle in RELOAD before loading MODULO
// and pulsing irq; otherwise MODULO is loaded directly on the overflow tick.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       tap_bits,
    input  logic             count_we,
    input  logic             modulo_we,
    input  logic             control_we,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] count_out,
    output logic [CNT_W-1:0] modulo_out,
    output logic [2:0]       control_out,
    output logic             irq
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] modulo_q, modulo_d;
    logic [2:0]       control_q, control_d;
    logic             irq_q, irq_d;
    logic             tick_prev_q, tick_prev_d;
    logic             tick_sig;
    logic             tick;

`ifdef TIMER_OVF_DELAY_EN
    ch_state_e state_q, state_d;

    // Overflow state register; reset drops any pending reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // Tick is the falling edge of the gated tap, whatever caused it
    always_comb begin
        tick_sig = control_q[2] & tap_bits[control_q[1:0]];
        tick     = tick_prev_q & ~tick_sig;
    end

    // Next-state: CPU writes, counting, overflow reload and irq generation
    always_comb begin
        count_d     = count_q;
        modulo_d    = modulo_q;
        control_d   = control_q;
        irq_d       = 1'b0;
        tick_prev_d = tick_sig;
`ifdef TIMER_OVF_DELAY_EN
        state_d     = state_q;
`endif
        if (modulo_we) begin
            modulo_d = wdata;
        end
        if (control_we) begin
            control_d = wdata[2:0];
        end
`ifdef TIMER_OVF_DELAY_EN
        if (state_q == RELOAD) begin
            // A COUNT write here aborts the reload; a same-cycle MODULO write is honoured
            state_d = IDLE;
            if (count_we) begin
                count_d = wdata;
            end else begin
                count_d = modulo_d;
                irq_d   = 1'b1;
            end
        end else if (count_we) begin
            count_d = wdata;
        end else if (tick) begin
            if (count_q == '1) begin
                count_d = '0;
                state_d = RELOAD;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
`else
        if (count_we) begin
            count_d = wdata;
        end else if (tick) begin
            if (count_q == '1) begin
                count_d = modulo_q;
                irq_d   = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
`endif
    end

    // Channel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            modulo_q    <= '0;
            control_q   <= '0;
            irq_q       <= 1'b0;
            tick_prev_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            modulo_q    <= modulo_d;
            control_q   <= control_d;
            irq_q       <= irq_d;
            tick_prev_q <= tick_prev_d;
        end
    end

    assign count_out   = count_q;
    assign modulo_out  = modulo_q;
    assign control_out = control_q;
    assign irq         = irq_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: shared free-running divider, register decode and read-back
// for NUM_CH timer_channel slices.
// Optional feature macro: TIMER_OVF_DELAY_EN (delayed overflow reload,
// implemented inside timer_channel).
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reg_we,
    input  logic                       reg_re,
    input  logic [$clog2(NUM_CH)+1:0]  reg_addr,
    input  logic [CNT_W-1:0]           reg_wdata,
    output logic [CNT_W-1:0]           reg_rdata,
    output logic [NUM_CH-1:0]          irq,
    output logic [DIV_W-1:0]           div_out
);

    localparam int AW = $clog2(NUM_CH) + 2;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] reg_rdata_q, reg_rdata_d;
    logic [1:0]       reg_off;
    logic [AW-1:0]    ch_sel;
    logic [3:0]       tap_bits;

    logic [CNT_W-1:0] count_w   [NUM_CH];
    logic [CNT_W-1:0] modulo_w  [NUM_CH];
    logic [2:0]       control_w [NUM_CH];

    assign reg_off = reg_addr[1:0];
    assign ch_sel  = reg_addr >> 2;

    // Divider counts every cycle; any DIV-offset write restarts it from zero
    always_comb begin
        div_d = div_q + 1'b1;
        if (reg_we && reg_off == REG_DIV) begin
            div_d = '0;
        end
    end

    // Present the four selectable divider taps in tap-select order
    always_comb begin
        tap_bits           = '0;
        tap_bits[TAP_BIT9] = div_q[9];
        tap_bits[TAP_BIT3] = div_q[3];
        tap_bits[TAP_BIT5] = div_q[5];
        tap_bits[TAP_BIT7] = div_q[7];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = (ch_sel == AW'(i));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tap_bits    (tap_bits),
            .count_we    (reg_we && sel && reg_off == REG_COUNT),
            .modulo_we   (reg_we && sel && reg_off == REG_MODULO),
            .control_we  (reg_we && sel && reg_off == REG_CONTROL),
            .wdata       (reg_wdata),
            .count_out   (count_w[i]),
            .modulo_out  (modulo_w[i]),
            .control_out (control_w[i]),
            .irq         (irq[i])
        );
    end

    // Read mux: capture on reg_re, otherwise hold; unmapped channels read 0
    always_comb begin
        reg_rdata_d = reg_rdata_q;
        if (reg_re) begin
            reg_rdata_d = '0;
            if (reg_off == REG_DIV) begin
                reg_rdata_d = div_q[DIV_W-1 -: CNT_W];
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == AW'(i)) begin
                        case (reg_off)
                            REG_COUNT:  reg_rdata_d = count_w[i];
                            REG_MODULO: reg_rdata_d = modulo_w[i];
                            default:    reg_rdata_d = {{(CNT_W-3){1'b1}}, control_w[i]};
                        endcase
                    end
                end
            end
        end
    end

    // Divider and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            reg_rdata_q <= '0;
        end else begin
            div_q       <= div_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    assign reg_rdata = reg_rdata_q;
    assign div_out   = div_q;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed, scoreboard-checked bench for multi_timer.
// Read and irq expectations are queued by the stimulus; a negedge monitor
// pops and compares them as the DUT presents data.
module tb_multi_timer;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 16;
    localparam int AW     = 3;

`ifdef TIMER_OVF_DELAY_EN
    localparam bit OVF_DELAY = 1'b1;
    localparam int OVF_LAT   = 2;
`else
    localparam bit OVF_DELAY = 1'b0;
    localparam int OVF_LAT   = 1;
`endif

    localparam logic [1:0] OFF_COUNT   = 2'b00;
    localparam logic [1:0] OFF_MODULO  = 2'b01;
    localparam logic [1:0] OFF_CONTROL = 2'b10;
    localparam logic [1:0] OFF_DIV     = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reg_we = 1'b0;
    logic              reg_re = 1'b0;
    logic [AW-1:0]     reg_addr = '0;
    logic [CNT_W-1:0]  reg_wdata = '0;
    logic [CNT_W-1:0]  reg_rdata;
    logic [NUM_CH-1:0] irq;
    logic [DIV_W-1:0]  div_out;

    multi_timer #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .irq      (irq),
        .div_out  (div_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        string      name;
    } rd_exp_t;

    typedef struct {
        logic [1:0] value;
        int         cyc;
        string      name;
    } irq_exp_t;

    rd_exp_t    rd_q[$];
    irq_exp_t   irq_q[$];
    rd_exp_t    rd_e;
    irq_exp_t   irq_e;
    int         vectors = 0;
    int         miscompares = 0;
    int         edge_cnt = 0;
    logic       rd_pend = 1'b0;
    logic [7:0] last_rdata = '0;
    int         d, e, f, g, h, k, m;

    // Cycle index and one-cycle-delayed read strobe (marks when reg_rdata is due)
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rd_pend  <= reg_re;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    function automatic logic [AW-1:0] addrOf(input int ch, input logic [1:0] off);
        logic [AW-1:0] a;
        a = {ch[0], off};
        return a;
    endfunction

    // Drive one strobe cycle; returns just after the edge that samples it
    task automatic applyStimulus(input logic we, input logic re, input logic [AW-1:0] a, input logic [7:0] wd);
        reg_we    = we;
        reg_re    = re;
        reg_addr  = a;
        reg_wdata = wd;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        reg_re = 1'b0;
    endtask

    task automatic writeReg(input logic [AW-1:0] a, input logic [7:0] wd);
        applyStimulus(1'b1, 1'b0, a, wd);
    endtask

    task automatic readReg(input logic [AW-1:0] a, input logic [7:0] exp_val, input string name);
        rd_q.push_back('{value: exp_val, name: name});
        applyStimulus(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic expectIrq(input logic [1:0] val, input int cyc, input string name);
        irq_q.push_back('{value: val, cyc: cyc, name: name});
    endtask

    // Advance to the start of a given cycle; landing late means the schedule broke
    task automatic gotoCycle(input int c);
        if (edge_cnt > c) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL schedule: at cycle %0d, expected to be at or before %0d", edge_cnt, c);
        end
        while (edge_cnt < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: returned read data, held read data, and irq pulses
    always @(negedge clk) begin
        if (rst) begin
            last_rdata = '0;
        end else begin
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_read: got %h, no read outstanding", reg_rdata);
                end else begin
                    rd_e = rd_q.pop_front();
                    checkOutput(rd_e.name, reg_rdata, rd_e.value);
                    last_rdata = rd_e.value;
                end
            end else begin
                checkOutput("rdata_hold", reg_rdata, last_rdata);
            end

            if (irq_q.size() > 0 && irq_q[0].cyc == edge_cnt) begin
                irq_e = irq_q.pop_front();
                checkOutput(irq_e.name, {6'b0, irq}, {6'b0, irq_e.value});
            end else begin
                if (irq_q.size() > 0 && irq_q[0].cyc < edge_cnt) begin
                    irq_e = irq_q.pop_front();
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL %s: got no pulse, expected irq=%b at cycle %0d", irq_e.name, irq_e.value, irq_e.cyc);
                end
                if (irq !== '0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_irq: got irq=%b, expected 00 (cycle %0d)", irq, edge_cnt);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        readReg(addrOf(0, OFF_COUNT),   8'h00, "rst_count0");
        readReg(addrOf(0, OFF_CONTROL), 8'hF8, "rst_control0");
        readReg(addrOf(1, OFF_MODULO),  8'h00, "rst_modulo1");
        readReg(addrOf(1, OFF_COUNT),   8'h00, "rst_count1");
        readReg(addrOf(0, OFF_DIV),     8'h00, "rst_div");

        // CH0 tap bit3 from 0xFE: one tick to 0xFF, next tick overflows to MODULO
        d = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'hAA);
        expectIrq(2'b01, d + 33 + OVF_LAT, "ovf_irq_ch0");
        writeReg(addrOf(0, OFF_MODULO),  8'h40);
        writeReg(addrOf(0, OFF_COUNT),   8'hFE);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(d + 5);
        readReg(addrOf(0, OFF_CONTROL), 8'hFD, "control_readback");
        gotoCycle(d + 17);
        readReg(addrOf(0, OFF_COUNT), 8'hFE, "count_before_tick");
        readReg(addrOf(0, OFF_COUNT), 8'hFF, "count_after_tick");
        gotoCycle(d + 34);
        readReg(addrOf(0, OFF_COUNT), OVF_DELAY ? 8'h00 : 8'h40, "count_ovf_next");
        gotoCycle(d + 36);
        readReg(addrOf(0, OFF_COUNT), 8'h40, "count_reloaded");
        writeReg(addrOf(0, OFF_CONTROL), 8'h00);

        // Divider clear while bit3 high ticks; COUNT write beats a tick; disable ticks
        e = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        writeReg(addrOf(0, OFF_COUNT),   8'h20);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(e + 10);
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        readReg(addrOf(0, OFF_COUNT), 8'h20, "div_clear_before");
        readReg(addrOf(0, OFF_COUNT), 8'h21, "div_clear_tick");
        gotoCycle(e + 27);
        writeReg(addrOf(0, OFF_COUNT), 8'h77);
        readReg(addrOf(0, OFF_COUNT), 8'h77, "write_beats_tick");
        readReg(addrOf(0, OFF_COUNT), 8'h77, "write_beats_tick_hold");
        gotoCycle(e + 36);
        writeReg(addrOf(0, OFF_CONTROL), 8'h00);
        gotoCycle(e + 39);
        readReg(addrOf(0, OFF_COUNT), 8'h78, "disable_tick");

        // CH0 tap bit3 and CH1 tap bit7 overflow together at divider 256
        f = edge_cnt;
        writeReg(addrOf(1, OFF_DIV), 8'h00);
        expectIrq(2'b11, f + 257 + OVF_LAT, "dual_irq");
        writeReg(addrOf(0, OFF_COUNT),   8'hFF);
        writeReg(addrOf(1, OFF_COUNT),   8'hFF);
        writeReg(addrOf(0, OFF_MODULO),  8'h10);
        writeReg(addrOf(1, OFF_MODULO),  8'h20);
        writeReg(addrOf(1, OFF_CONTROL), 8'h07);
        gotoCycle(f + 249);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(f + 260);
        readReg(addrOf(0, OFF_COUNT), 8'h10, "dual_count0");
        readReg(addrOf(1, OFF_COUNT), 8'h20, "dual_count1");
        writeReg(addrOf(0, OFF_CONTROL), 8'h00);
        writeReg(addrOf(1, OFF_CONTROL), 8'h00);
        readReg(addrOf(1, OFF_CONTROL), 8'hF8, "ch1_disabled");

        // COUNT write in the cycle after overflow (cancels reload and irq when delayed)
        g = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        if (!OVF_DELAY) expectIrq(2'b01, g + 18, "ovf_irq_direct");
        writeReg(addrOf(0, OFF_MODULO),  8'h40);
        writeReg(addrOf(0, OFF_COUNT),   8'hFF);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(g + 18);
        writeReg(addrOf(0, OFF_COUNT), 8'h10);
        readReg(addrOf(0, OFF_COUNT), 8'h10, "reload_cancel");
        readReg(addrOf(0, OFF_COUNT), 8'h10, "reload_cancel_hold");
        writeReg(addrOf(0, OFF_CONTROL), 8'h00);

        // MODULO write in the cycle after overflow
        h = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        expectIrq(2'b01, h + 17 + OVF_LAT, "ovf_irq_modulo");
        writeReg(addrOf(0, OFF_MODULO),  8'h40);
        writeReg(addrOf(0, OFF_COUNT),   8'hFF);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(h + 18);
        writeReg(addrOf(0, OFF_MODULO), 8'h66);
        gotoCycle(h + 20);
        readReg(addrOf(0, OFF_COUNT),  OVF_DELAY ? 8'h66 : 8'h40, "reload_modulo");
        readReg(addrOf(0, OFF_MODULO), 8'h66, "modulo_readback");
        writeReg(addrOf(0, OFF_CONTROL), 8'h00);

        // Reset in the cycle after overflow: everything cleared, no irq afterwards
        k = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        writeReg(addrOf(0, OFF_MODULO),  8'h40);
        writeReg(addrOf(0, OFF_COUNT),   8'hFF);
        writeReg(addrOf(0, OFF_CONTROL), 8'h05);
        gotoCycle(k + 18);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        readReg(addrOf(0, OFF_COUNT),   8'h00, "rst_mid_count");
        readReg(addrOf(0, OFF_MODULO),  8'h00, "rst_mid_modulo");
        readReg(addrOf(0, OFF_CONTROL), 8'hF8, "rst_mid_control");
        repeat (20) @(posedge clk);
        #1;

        // Divider read-back returns the top byte
        m = edge_cnt;
        writeReg(addrOf(0, OFF_DIV), 8'h00);
        gotoCycle(m + 256);
        readReg(addrOf(0, OFF_DIV), 8'h00, "div_00ff");
        readReg(addrOf(1, OFF_DIV), 8'h01, "div_0100");
        gotoCycle(m + 4661);
        readReg(addrOf(0, OFF_DIV), 8'h12, "div_1234");

        repeat (40) @(posedge clk);
        #1;
        while (rd_q.size() > 0) begin
            rd_e = rd_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got no read data, expected %h", rd_e.name, rd_e.value);
        end
        while (irq_q.size() > 0) begin
            irq_e = irq_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got no pulse, expected irq=%b", irq_e.name, irq_e.value);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent timer channels, 1..8.
REQ-002 Parameter CNT_W, default 8: width of each channel's COUNT and MODULO registers.
REQ-003 Parameter DIV_W, default 16: width of the free-running divider; minimum 10.
REQ-004 clk  input  1  CPU clock; the block SHALL use rising edges only.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 reg_we  input  1  register write strobe, single cycle.
REQ-007 reg_re  input  1  register read strobe, single cycle.
REQ-008 reg_addr  input  $clog2(NUM_CH)+2  upper bits select the channel; [1:0] select the register: 00 COUNT, 01 MODULO, 10 CONTROL, 11 DIV.
REQ-009 reg_wdata  input  CNT_W  write data.
REQ-010 reg_rdata  output  CNT_W  read data, registered.
REQ-011 irq  output  NUM_CH  per-channel overflow interrupt, one-cycle pulse.
REQ-012 div_out  output  DIV_W  current divider value.

Function
REQ-013 The divider SHALL increment by 1 every clk cycle and wrap from all-ones to 0.
REQ-014 A write to any address with [1:0]=11 SHALL clear the divider to 0 in the following cycle; reg_wdata is ignored.
REQ-015 CONTROL bit 2 is the enable; bits 1:0 select the divider tap: 00 bit 9, 01 bit 3, 10 bit 5, 11 bit 7.
REQ-016 Per channel, tick_sig = CONTROL[2] AND divider[tap]; a tick SHALL occur on every 1->0 transition of tick_sig between consecutive cycles.
REQ-017 Ticks caused by a divider clear, a disable, or a tap change SHALL count as ticks.
REQ-018 On a tick with COUNT < all-ones, COUNT SHALL increment by 1.
REQ-019 On a tick with COUNT = all-ones, the channel SHALL overflow (see REQ-026/027).
REQ-020 When a CPU write to COUNT and a tick land in the same cycle, the write SHALL win and the tick is lost.
REQ-021 Writes to MODULO and CONTROL SHALL take effect in the following cycle.
REQ-022 Reads SHALL return data in reg_rdata one cycle after reg_re; reg_rdata SHALL hold its value otherwise.
REQ-023 Read at [1:0]=11 SHALL return divider bits [DIV_W-1 -: CNT_W].
REQ-024 Reads of CONTROL SHALL return bits [CNT_W-1:3] as 1.
REQ-025 Channels SHALL be fully independent; simultaneous overflows on several channels SHALL assert several irq bits in the same cycle.

Configuration
REQ-026 With TIMER_OVF_DELAY_EN defined:
- The overflow cycle SHALL load COUNT=0 and enter state RELOAD for exactly one cycle.
- In the next cycle COUNT SHALL load MODULO and the irq bit SHALL pulse.
- A COUNT write during RELOAD SHALL cancel both the reload and the irq.
- A MODULO write during RELOAD SHALL make the new value the one loaded.
- Per-channel state machine: IDLE -> RELOAD -> IDLE.
REQ-027 Without TIMER_OVF_DELAY_EN:
- The overflow cycle SHALL load MODULO directly.
- irq SHALL pulse in the cycle after the overflow tick.
- There is no RELOAD state.

Reset
REQ-028 Reset SHALL clear the divider, and every COUNT, MODULO, CONTROL, irq and reg_rdata, to 0; all channels SHALL return to IDLE.
REQ-029 The tick_sig history SHALL reset to 0, so that no tick occurs on the first cycle after reset.
REQ-030 Reset asserted mid-RELOAD SHALL discard the pending reload and its irq.

Structure
REQ-031 A shared package SHALL hold:
- the register-offset constants (COUNT, MODULO, CONTROL, DIV);
- the tap-select enum;
- the channel-state enum (IDLE, RELOAD).
REQ-032 Per-channel logic SHALL be one sub-module, timer_channel, instantiated NUM_CH times by a generate loop; the divider and register decode stay in multi_timer.

Verification
REQ-033 CH0 CONTROL=0x05, COUNT=0xFE, MODULO=0x40 -> COUNT=0xFF after 16 cycles; irq[0] pulses after 32 cycles; COUNT=0x40.
REQ-034 With TIMER_OVF_DELAY_EN, a COUNT=0x10 write in the cycle after overflow -> COUNT=0x10 and no irq[0] pulse.
REQ-035 CH0 CONTROL=0x05, with divider bit 3 = 1 at the DIV write -> COUNT increments by exactly 1 in the cycle after the DIV write.
REQ-036 CH0 tap 01 and CH1 tap 11, both enabled and both at 0xFF, timed to overflow together -> irq=2'b11 in one cycle.
REQ-037 Reset asserted during RELOAD -> COUNT=0, irq=0, no pulse after rst deasserts.
REQ-038 Read DIV at divider=0x1234 -> reg_rdata=0x12 one cycle later.
